// File: rtl/systolic_skew_feeder.sv
// Operand skew feeder: buffers one K-beat A/B tile, then replays it as diagonally
// skewed row/column streams (lane r delayed by r cycles) for a systolic array.
module systolic_skew_feeder #(
  parameter int DBITS = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int K     = 2
) (
  input  logic                    i_CLK,
  input  logic                    i_RSTN,
  input  logic                    i_LD_VALID,
  output logic                    o_LD_READY,
  input  logic [ROWS*DBITS-1:0]   i_LD_A,
  input  logic [COLS*DBITS-1:0]   i_LD_B,
  output logic [ROWS*DBITS-1:0]   o_A,
  output logic [ROWS-1:0]         o_A_VALID,
  output logic [COLS*DBITS-1:0]   o_B,
  output logic [COLS-1:0]         o_B_VALID,
  output logic                    o_BUSY,
  output logic                    o_DONE
);

  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int S     = K + MAXRC - 1;
  localparam int BW    = (K > 1) ? $clog2(K) : 1;
  localparam int SW    = (S > 1) ? $clog2(S) : 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FEED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [SW-1:0]           slot_q, slot_d;

  // a_buf[r][k] = A[r][k]; b_buf[k][c] = B[k][c].
  logic [DBITS-1:0]        a_buf_q [ROWS][K];
  logic [DBITS-1:0]        a_buf_d [ROWS][K];
  logic [DBITS-1:0]        b_buf_q [K][COLS];
  logic [DBITS-1:0]        b_buf_d [K][COLS];

  logic [ROWS*DBITS-1:0]   a_q, a_d;
  logic [ROWS-1:0]         a_valid_q, a_valid_d;
  logic [COLS*DBITS-1:0]   b_q, b_d;
  logic [COLS-1:0]         b_valid_q, b_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ld_ready_q, ld_ready_d;

  logic                    ld_fire;

  // Handshake: a beat transfers on a rising edge where i_LD_VALID and o_LD_READY
  // are both high; o_LD_READY is registered and high exactly while in LOAD.
  assign ld_fire = ld_ready_q & i_LD_VALID;

  // Next-state, buffer write and counter logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    slot_d  = slot_q;
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;

    case (state_q)
      ST_LOAD: begin
        if (ld_fire) begin
          for (int k = 0; k < K; k++) begin
            if (beat_q == BW'(k)) begin
              for (int r = 0; r < ROWS; r++) begin
                a_buf_d[r][k] = i_LD_A[r*DBITS +: DBITS];
              end
              for (int c = 0; c < COLS; c++) begin
                b_buf_d[k][c] = i_LD_B[c*DBITS +: DBITS];
              end
            end
          end
          if (beat_q == BW'(K - 1)) begin
            state_d = ST_FEED;
            beat_d  = '0;
            slot_d  = '0;
          end else begin
            beat_d  = beat_q + BW'(1);
          end
        end
      end
      ST_FEED: begin
        if (slot_q == SW'(S - 1)) begin
          state_d = ST_LOAD;
          slot_d  = '0;
        end else begin
          slot_d  = slot_q + SW'(1);
        end
      end
      default: begin
        state_d = ST_LOAD;
        beat_d  = '0;
        slot_d  = '0;
      end
    endcase
  end

  // Output registers load the slot that will be visible next cycle. Reading the
  // post-write buffer lets slot 0 see the beat captured on the same edge (K = 1).
  always_comb begin
    a_d        = '0;
    a_valid_d  = '0;
    b_d        = '0;
    b_valid_d  = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ld_ready_d = 1'b1;

    if (state_d == ST_FEED) begin
      busy_d     = 1'b1;
      ld_ready_d = 1'b0;
      done_d     = (slot_d == SW'(S - 1));
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < K; k++) begin
          if (slot_d == SW'(r + k)) begin
            a_d[r*DBITS +: DBITS] = a_buf_d[r][k];
            a_valid_d[r]          = 1'b1;
          end
        end
      end
      for (int c = 0; c < COLS; c++) begin
        for (int k = 0; k < K; k++) begin
          if (slot_d == SW'(c + k)) begin
            b_d[c*DBITS +: DBITS] = b_buf_d[k][c];
            b_valid_d[c]          = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q    <= ST_LOAD;
      beat_q     <= '0;
      slot_q     <= '0;
      a_q        <= '0;
      a_valid_q  <= '0;
      b_q        <= '0;
      b_valid_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      slot_q     <= slot_d;
      a_q        <= a_d;
      a_valid_q  <= a_valid_d;
      b_q        <= b_d;
      b_valid_q  <= b_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ld_ready_q <= ld_ready_d;
    end
  end

  // Tile storage carries no reset; its contents only matter after a full load.
  always_ff @(posedge i_CLK) begin
    a_buf_q <= a_buf_d;
    b_buf_q <= b_buf_d;
  end

  assign o_A        = a_q;
  assign o_A_VALID  = a_valid_q;
  assign o_B        = b_q;
  assign o_B_VALID  = b_valid_q;
  assign o_BUSY     = busy_q;
  assign o_DONE     = done_q;
  assign o_LD_READY = ld_ready_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with DBITS=8, ROWS=COLS=K=2.
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [15:0] ld_a;
  logic [15:0] ld_b;
  wire         ld_ready;
  wire  [15:0] a_out;
  wire  [1:0]  a_vld;
  wire  [15:0] b_out;
  wire  [1:0]  b_vld;
  wire         busy;
  wire         done;

  int tests = 0;
  int fails = 0;

  // Observed vector: {o_A, o_A_VALID, o_B, o_B_VALID, o_DONE, o_BUSY, o_LD_READY}
  wire  [38:0] obs = {a_out, a_vld, b_out, b_vld, done, busy, ld_ready};
  localparam logic [38:0] IDLE = 39'h1;

  systolic_skew_feeder #(.DBITS(8), .ROWS(2), .COLS(2), .K(2)) dut (
    .i_CLK      (clk),
    .i_RSTN     (rst_n),
    .i_LD_VALID (ld_valid),
    .o_LD_READY (ld_ready),
    .i_LD_A     (ld_a),
    .i_LD_B     (ld_b),
    .o_A        (a_out),
    .o_A_VALID  (a_vld),
    .o_B        (b_out),
    .o_B_VALID  (b_vld),
    .o_BUSY     (busy),
    .o_DONE     (done)
  );

  always #5 clk = ~clk;

  // Beats for A=[[1,2],[3,4]], B=[[5,6],[7,8]], every element plus off.
  function automatic logic [15:0] beat_a(input int k, input int off);
    logic [7:0] o8 = 8'(off);
    return ((k == 0) ? 16'h0301 : 16'h0402) + {o8, o8};
  endfunction

  function automatic logic [15:0] beat_b(input int k, input int off);
    logic [7:0] o8 = 8'(off);
    return ((k == 0) ? 16'h0605 : 16'h0807) + {o8, o8};
  endfunction

  // Hand-computed skewed slots, offset added to valid lanes only.
  function automatic logic [38:0] exp_slot(input int t, input int off);
    logic [15:0] ea;
    logic [15:0] eb;
    logic [1:0]  v;
    logic [7:0]  o8 = 8'(off);
    case (t)
      0:       begin ea = 16'h0001; eb = 16'h0005; v = 2'b01; end
      1:       begin ea = 16'h0302; eb = 16'h0607; v = 2'b11; end
      default: begin ea = 16'h0400; eb = 16'h0800; v = 2'b10; end
    endcase
    ea = ea + {(v[1] ? o8 : 8'h00), (v[0] ? o8 : 8'h00)};
    eb = eb + {(v[1] ? o8 : 8'h00), (v[0] ? o8 : 8'h00)};
    return {ea, v, eb, v, (t == 2), 1'b1, 1'b0};
  endfunction

  task automatic drive_beat(input int k, input int off);
    ld_valid = 1'b1;
    ld_a     = beat_a(k, off);
    ld_b     = beat_b(k, off);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_a     = '0;
    ld_b     = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ld_valid = 1'b0;
    ld_a = '0;
    ld_b = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL reset_hold: got %h expected %h", obs, IDLE);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL reset_release: got %h expected %h", obs, IDLE);
    end
  endtask

  task automatic test_basic();
    drive_beat(0, 0);
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL basic_after_beat0: got %h expected %h", obs, IDLE);
    end
    drive_beat(1, 0);
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (obs !== exp_slot(t, 0)) begin
        fails++;
        $display("FAIL basic_slot%0d: got %h expected %h", t, obs, exp_slot(t, 0));
      end
      @(posedge clk); #1;
    end
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL basic_end: got %h expected %h", obs, IDLE);
    end
  endtask

  task automatic test_gap();
    drive_beat(0, 0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs !== IDLE) begin
        fails++;
        $display("FAIL gap_idle%0d: got %h expected %h", i, obs, IDLE);
      end
      @(posedge clk); #1;
    end
    drive_beat(1, 0);
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (obs !== exp_slot(t, 0)) begin
        fails++;
        $display("FAIL gap_slot%0d: got %h expected %h", t, obs, exp_slot(t, 0));
      end
      @(posedge clk); #1;
    end
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL gap_end: got %h expected %h", obs, IDLE);
    end
  endtask

  task automatic test_hold_valid();
    ld_valid = 1'b1;
    ld_a = beat_a(0, 0);
    ld_b = beat_b(0, 0);
    @(posedge clk); #1;
    ld_a = beat_a(1, 0);
    ld_b = beat_b(1, 0);
    @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin
      ld_a = 16'hEE00 + 16'(t);
      ld_b = 16'hDD00 + 16'(t);
      tests++;
      if (obs !== exp_slot(t, 0)) begin
        fails++;
        $display("FAIL hold_slot%0d: got %h expected %h", t, obs, exp_slot(t, 0));
      end
      @(posedge clk); #1;
    end
    ld_a = beat_a(0, 16);
    ld_b = beat_b(0, 16);
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL hold_reload: got %h expected %h", obs, IDLE);
    end
    @(posedge clk); #1;
    ld_a = beat_a(1, 16);
    ld_b = beat_b(1, 16);
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL hold_beat0_taken: got %h expected %h", obs, IDLE);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_a = '0;
    ld_b = '0;
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (obs !== exp_slot(t, 16)) begin
        fails++;
        $display("FAIL hold_next_slot%0d: got %h expected %h", t, obs, exp_slot(t, 16));
      end
      @(posedge clk); #1;
    end
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL hold_end: got %h expected %h", obs, IDLE);
    end
  endtask

  task automatic test_reset_mid_feed();
    drive_beat(0, 0);
    drive_beat(1, 0);
    tests++;
    if (obs !== exp_slot(0, 0)) begin
      fails++;
      $display("FAIL rstmid_slot0: got %h expected %h", obs, exp_slot(0, 0));
    end
    @(posedge clk); #1;
    tests++;
    if (obs !== exp_slot(1, 0)) begin
      fails++;
      $display("FAIL rstmid_slot1: got %h expected %h", obs, exp_slot(1, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL rstmid_async: got %h expected %h", obs, IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL rstmid_released: got %h expected %h", obs, IDLE);
    end
    drive_beat(0, 0);
    drive_beat(1, 0);
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (obs !== exp_slot(t, 0)) begin
        fails++;
        $display("FAIL rstmid_fresh_slot%0d: got %h expected %h", t, obs, exp_slot(t, 0));
      end
      @(posedge clk); #1;
    end
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL rstmid_end: got %h expected %h", obs, IDLE);
    end
  endtask

  task automatic test_back_to_back();
    drive_beat(0, 0);
    drive_beat(1, 0);
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (obs !== exp_slot(t, 0)) begin
        fails++;
        $display("FAIL b2b_first_slot%0d: got %h expected %h", t, obs, exp_slot(t, 0));
      end
      @(posedge clk); #1;
    end
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL b2b_gap: got %h expected %h", obs, IDLE);
    end
    drive_beat(0, 16);
    drive_beat(1, 16);
    for (int t = 0; t < 3; t++) begin
      tests++;
      if (obs !== exp_slot(t, 16)) begin
        fails++;
        $display("FAIL b2b_second_slot%0d: got %h expected %h", t, obs, exp_slot(t, 16));
      end
      @(posedge clk); #1;
    end
    tests++;
    if (obs !== IDLE) begin
      fails++;
      $display("FAIL b2b_end: got %h expected %h", obs, IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_hold_valid();
    test_reset_mid_feed();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Transmit side of the systolic array core's A/B input interface.
- Accepts one operand tile as K load beats over a valid/ready handshake and buffers it.
- Replays the tile as diagonally skewed row (A) and column (B) streams with per-lane valid bits: row r and column c are delayed by r and c cycles respectively.
- Outputs connect directly to the array's A, B, A_VALID and B_VALID inputs. Sits between the operand fetch logic and the array core.

Parameters:
- DBITS, 8, operand width in bits.
- ROWS, 2, number of A lanes (array rows).
- COLS, 2, number of B lanes (array columns).
- K, 2, inner dimension: beats per tile, and entries per lane per tile.

Ports:
- i_CLK  input  1  clock, rising edge.
- i_RSTN  input  1  asynchronous active-low reset.
- i_LD_VALID  input  1  load beat valid.
- o_LD_READY  output  1  load beat accepted when both i_LD_VALID and o_LD_READY are high.
- i_LD_A  input  ROWS*DBITS  beat k: A[r][k] in lane r, bits [(r+1)*DBITS-1 : r*DBITS].
- i_LD_B  input  COLS*DBITS  beat k: B[k][c] in lane c, same packing.
- o_A  output  ROWS*DBITS  skewed A stream, lane packing as above.
- o_A_VALID  output  ROWS  per-row valid.
- o_B  output  COLS*DBITS  skewed B stream.
- o_B_VALID  output  COLS  per-column valid.
- o_BUSY  output  1  high while in FEED.
- o_DONE  output  1  one-cycle pulse, coincident with the last feed slot.

Behaviour:
- Reset (async assert, sync release):
  - State goes to LOAD; beat counter and slot counter go to 0.
  - o_A, o_B, o_A_VALID, o_B_VALID, o_BUSY and o_DONE go to 0; o_LD_READY goes to 1.
  - Buffer contents are don't-care. A reset during FEED aborts the tile; no partial stream resumes.
- State LOAD:
  - o_LD_READY = 1.
  - Each accepted beat writes buffer column k = beat counter, then the beat counter increments.
  - Stream outputs hold 0 and all valids hold 0.
  - On the edge accepting beat K-1: state goes to FEED, the beat counter clears, and the output registers load slot 0.
- State FEED:
  - o_LD_READY = 0 and o_BUSY = 1; i_LD_* is ignored.
  - S = K + max(ROWS,COLS) - 1 slots are emitted on consecutive cycles with no gaps and no stall input.
  - Slot t, lane r of A: valid = (0 <= t-r < K); data = A[r][t-r] when valid, else 0.
  - Slot t, lane c of B: valid = (0 <= t-c < K); data = B[t-c][c] when valid, else 0.
  - The first slot becomes visible in the cycle immediately after the final load handshake, so load-to-first-output latency is 1 cycle.
  - o_DONE = 1 only while slot S-1 is visible.
  - On the edge after slot S-1: state goes to LOAD, outputs and valids clear to 0, o_BUSY and o_DONE go to 0, and o_LD_READY goes to 1.
- All outputs are registered; there is no combinational path from input to output.
- Back-to-back tiles: the next load can start the cycle after o_DONE. Minimum tile period is K + S cycles.
- i_LD_VALID held high across the LOAD-to-FEED boundary: no beat is accepted while o_LD_READY = 0, and no data is lost.
- K = 1 is legal: a single beat goes straight to FEED.
- Counter widths are clog2 of their range, minimum 1 bit.

Test Plan:
All cases use DBITS=8, ROWS=COLS=K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Beat0 is i_LD_A=16'h0301, i_LD_B=16'h0605; beat1 is 16'h0402 / 16'h0807.
1. Reset -> o_LD_READY=1; all stream outputs, valids, o_BUSY and o_DONE are 0.
2. Load beat0 then beat1 on consecutive cycles -> next three cycles carry:
   - o_A 16'h0001/2'b01, 16'h0302/2'b11, 16'h0400/2'b10;
   - o_B 16'h0005/2'b01, 16'h0607/2'b11, 16'h0800/2'b10;
   - o_DONE on the third cycle only; then all outputs 0 and o_LD_READY=1.
3. Insert 3 idle cycles (i_LD_VALID=0) between beat0 and beat1 -> identical stream to case 2, starting 1 cycle after beat1.
4. Hold i_LD_VALID=1 with changing data through FEED -> o_LD_READY=0 for 3 cycles; the first beat presented after o_DONE is captured as beat0 of the next tile.
5. Deassert i_RSTN during the second FEED slot -> outputs are 0 immediately (asynchronously); after release the block is in LOAD, and a fresh tile streams exactly as in case 2.
6. Two tiles back-to-back, with the second using A and B incremented by 16 -> the second stream starts 3 cycles after the first tile's o_DONE with correctly offset values, and no cross-tile data mixing.
